// File: rtl/rr_arbiter_ctrl.sv
// N-requester round-robin arbiter with registered one-hot grant and bounded hold time.
// Optional ARB_PRIO0_EN: requester 0 preempts and wins every arbitration it requests.
module rr_arbiter_ctrl #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id
);
  localparam int ID_W = $clog2(N);
  localparam int HW   = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic [ID_W-1:0] last_id_q, last_id_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic [N-1:0]    owner_oh, others;
  logic            own_req, others_any;

  // First set bit of r searching upward from last+1, wrapping at N-1.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] r, input logic [ID_W-1:0] last);
    logic [ID_W-1:0] w;
    logic            found;
    int              idx;
    w     = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!found && r[idx]) begin
        w     = ID_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    owner_oh           = '0;
    owner_oh[gnt_id_q] = 1'b1;
  end

  assign own_req    = req[gnt_id_q];
  assign others     = req & ~owner_oh;
  assign others_any = |others;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      last_id_q   <= ID_W'(N - 1);
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      last_id_q   <= last_id_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
    hold_d    = hold_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          hold_d  = HOLD_ONE;
`ifdef ARB_PRIO0_EN
          if (req[0]) begin
            gnt_id_d = '0;
          end else begin
            gnt_id_d  = rr_pick(req, last_id_q);
            last_id_d = gnt_id_d;
          end
`else
          gnt_id_d  = rr_pick(req, last_id_q);
          last_id_d = gnt_id_d;
`endif
        end
      end
      GRANT: begin
`ifdef ARB_PRIO0_EN
        if (req[0] && gnt_id_q != '0) begin
          gnt_id_d = '0;
          hold_d   = HOLD_ONE;
        end else
`endif
        if (!own_req) begin
          if (others_any) begin
            gnt_id_d  = rr_pick(req, last_id_q);
            last_id_d = gnt_id_d;
            hold_d    = HOLD_ONE;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end else begin
          // Expiry: hand off if anyone else waits, otherwise restart the window.
          hold_d = HOLD_ONE;
          if (others_any) begin
            gnt_id_d  = rr_pick(others, last_id_q);
            last_id_d = gnt_id_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    gnt_valid_d = (state_d == GRANT);
    if (state_d == GRANT) gnt_d[gnt_id_d] = 1'b1;
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Directed bench for rr_arbiter_ctrl (N=4, MAX_HOLD=4) with hand-computed grants.
module tb_rr_arbiter_ctrl;
  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;

  int nvec = 0;
  int nerr = 0;

  rr_arbiter_ctrl #(.N(N), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_g(input string tag, input logic [3:0] eg, input logic [1:0] eid);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".vld"}, 32'(gnt_valid), 32'(|eg));
    chk({tag, ".id"}, 32'(gnt_id), 32'(eid));
  endtask

  initial begin
    logic [3:0] eg;
    reset = 1'b0;
    req   = '0;
    #12;
    chk_g("reset", 4'b0000, 2'd0);
    reset = 1'b1;

`ifndef ARB_PRIO0_EN
    // All requesting: 0,1,2,3,0 with four cycles each, no bubbles.
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      step();
      eg = 4'b0001 << ((c / 4) % 4);
      chk_g($sformatf("rr_c%0d", c), eg, 2'((c / 4) % 4));
    end
    req = '0;
    step();
    chk_g("rr_release", 4'b0000, 2'd0);
`endif

    // Short burst from requester 2, then idle with id retained.
    req = 4'b0100;
    step(); chk_g("burst_1", 4'b0100, 2'd2);
    step(); chk_g("burst_2", 4'b0100, 2'd2);
    req = '0;
    step(); chk_g("burst_idle", 4'b0000, 2'd2);

    // Owner 1 keeps its full window before requester 3 gets in.
    req = 4'b0010;
    step(); chk_g("hold_1", 4'b0010, 2'd1);
    req = 4'b1010;
    for (int c = 2; c <= 4; c++) begin
      step(); chk_g($sformatf("hold_%0d", c), 4'b0010, 2'd1);
    end
    step(); chk_g("hold_handoff", 4'b1000, 2'd3);

    // Owner 3 drops with requester 0 waiting: wrap with no bubble.
    req = 4'b0001;
    step(); chk_g("wrap", 4'b0001, 2'd0);
    req = '0;
    step(); chk_g("wrap_idle", 4'b0000, 2'd0);

    // Lone requester keeps the grant across hold-window boundaries.
    req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      step(); chk_g($sformatf("lone_%0d", c), 4'b0100, 2'd2);
    end
    req = '0;
    step(); chk_g("lone_idle", 4'b0000, 2'd2);

    // Owner 2, requester 0 arrives.
    req = 4'b0100;
    step(); chk_g("p0_own2", 4'b0100, 2'd2);
    req = 4'b0101;
`ifdef ARB_PRIO0_EN
    step(); chk_g("p0_preempt", 4'b0001, 2'd0);
`else
    for (int c = 0; c < 3; c++) begin
      step(); chk_g($sformatf("p0_keep_%0d", c), 4'b0100, 2'd2);
    end
    step(); chk_g("p0_expiry", 4'b0001, 2'd0);
`endif
    req = '0;
    step(); chk_g("p0_idle", 4'b0000, 2'd0);

    // Asynchronous reset between edges drops the grant immediately.
    req = 4'b1111;
    step();
    chk("arst_pre.vld", 32'(gnt_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk_g("arst", 4'b0000, 2'd0);
    req = 4'b1010;
    #2 reset = 1'b1;
    step(); chk_g("arst_first", 4'b0010, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
